// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: load/store/branch types and FSM states.
// Also holds the sign-extension helpers used by the load path.
package mem_pkg;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } load_t;

    typedef enum logic [1:0] {
        ST_SW = 2'd0,
        ST_SB = 2'd1,
        ST_SH = 2'd2
    } store_t;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BGEZ = 3'd1,
        BR_BGTZ = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BLTZ = 3'd4,
        BR_BNE  = 3'd5
    } br_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// EX/MEM inputs and MEM/WB + redirect outputs of the memory access stage.
// master = upstream pipeline / bench, slave = mem_access_unit.
interface mem_access_unit_if;

    logic [31:0] ex_mem_alu_out;
    logic [31:0] ex_mem_reg_b_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_ctrl_reg_write;
    logic        ex_mem_ctrl_mem_to_reg;
    logic        ex_mem_ctrl_mem_write;
    logic        ex_mem_ctrl_branch;
    logic        ex_mem_ctrl_jump;
    logic        ex_mem_ctrl_jump_reg;
    logic [2:0]  ex_mem_ctrl_load_type;
    logic [1:0]  ex_mem_ctrl_store_type;
    logic [2:0]  ex_mem_ctrl_branch_type;
    logic [5:0]  ex_mem_cond;

    logic        branch_taken;
    logic        jump_taken;
    logic        stall;
    logic        mem_wb_ctrl_reg_write;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rd;
    logic        addr_err;

    modport master (
        output ex_mem_alu_out, ex_mem_reg_b_data, ex_mem_rd,
        output ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg,
        output ex_mem_ctrl_mem_write, ex_mem_ctrl_branch,
        output ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg,
        output ex_mem_ctrl_load_type, ex_mem_ctrl_store_type,
        output ex_mem_ctrl_branch_type, ex_mem_cond,
        input  branch_taken, jump_taken, stall,
        input  mem_wb_ctrl_reg_write, mem_wb_data, mem_wb_rd,
        input  addr_err
    );

    modport slave (
        input  ex_mem_alu_out, ex_mem_reg_b_data, ex_mem_rd,
        input  ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg,
        input  ex_mem_ctrl_mem_write, ex_mem_ctrl_branch,
        input  ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg,
        input  ex_mem_ctrl_load_type, ex_mem_ctrl_store_type,
        input  ex_mem_ctrl_branch_type, ex_mem_cond,
        output branch_taken, jump_taken, stall,
        output mem_wb_ctrl_reg_write, mem_wb_data, mem_wb_rd,
        output addr_err
    );

endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering: store data replication + byte enables, load lane
// select + extension, and misalignment detection for both directions.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  store_type_i,
    input  logic [2:0]  load_type_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_word_i,
    output logic [31:0] wr_data_o,
    output logic [3:0]  be_o,
    output logic        st_mis_o,
    output logic [31:0] ld_data_o,
    output logic        ld_mis_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o      = 4'h0;
        wr_data_o = st_data_i;
        st_mis_o  = 1'b0;
        unique case (store_type_i)
            ST_SW: begin
                be_o     = 4'hF;
                st_mis_o = |off_i;
            end
            ST_SB: begin
                be_o      = 4'b0001 << off_i;
                wr_data_o = {4{st_data_i[7:0]}};
            end
            ST_SH: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                wr_data_o = {2{st_data_i[15:0]}};
                st_mis_o  = off_i[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (off_i)
            2'd0: byte_v = rd_word_i[7:0];
            2'd1: byte_v = rd_word_i[15:8];
            2'd2: byte_v = rd_word_i[23:16];
            default: byte_v = rd_word_i[31:24];
        endcase
    end

    assign half_v = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    always_comb begin
        ld_data_o = rd_word_i;
        ld_mis_o  = 1'b0;
        unique case (load_type_i)
            LD_LW:  ld_mis_o = |off_i;
            LD_LB:  ld_data_o = sext8(byte_v);
            LD_LBU: ld_data_o = {24'h0, byte_v};
            LD_LH: begin
                ld_data_o = sext16(half_v);
                ld_mis_o  = off_i[0];
            end
            LD_LHU: begin
                ld_data_o = {16'h0, half_v};
                ld_mis_o  = off_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: data memory, load-latency stall FSM, branch/jump resolution
// and the MEM/WB pipeline register.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    localparam int   LatM1  = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic HasLat = (RD_LAT > 0);

    logic [31:0] mem_q [0:2**ADDR_W-1];

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q;
    logic [2:0]  ltype_q;
    logic [4:0]  rd_q;
    logic        rw_q;

    logic        wb_rw_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;
    logic        err_q;

    logic        in_wait;
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [2:0]  ltype;
    logic [ADDR_W-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] wr_data;
    logic [3:0]  be;
    logic        st_mis_raw;
    logic        ld_mis_raw;
    logic [31:0] ld_data;
    logic        mis;
    logic        start;
    logic        stall;
    logic        done;
    logic        we;
    logic        br_sel;
    logic        unused_hi;

    assign in_wait  = (state_q == S_WAIT);
    assign is_load  = bus.ex_mem_ctrl_mem_to_reg;
    assign is_store = bus.ex_mem_ctrl_mem_write;

    // While waiting, the load in flight is served from its latched copy.
    assign addr  = in_wait ? addr_q  : bus.ex_mem_alu_out;
    assign ltype = in_wait ? ltype_q : bus.ex_mem_ctrl_load_type;

    assign idx       = addr[ADDR_W+1:2];
    assign unused_hi = ^addr[31:ADDR_W+2];
    assign rd_word   = mem_q[idx];

    load_store_align u_align (
        .off_i        (addr[1:0]),
        .store_type_i (bus.ex_mem_ctrl_store_type),
        .load_type_i  (ltype),
        .st_data_i    (bus.ex_mem_reg_b_data),
        .rd_word_i    (rd_word),
        .wr_data_o    (wr_data),
        .be_o         (be),
        .st_mis_o     (st_mis_raw),
        .ld_data_o    (ld_data),
        .ld_mis_o     (ld_mis_raw)
    );

    assign mis = !in_wait
               && ((is_load && ld_mis_raw) || (is_store && st_mis_raw));

    assign start = HasLat && !in_wait && is_load && !ld_mis_raw;
    assign stall = rst_n && (start || (in_wait && cnt_q != 3'd0));
    assign done  = in_wait && (cnt_q == 3'd0);
    assign we    = is_store && !st_mis_raw && !in_wait;

    always_comb begin
        unique case (bus.ex_mem_ctrl_branch_type)
            BR_BEQ:  br_sel = bus.ex_mem_cond[0];
            BR_BGEZ: br_sel = bus.ex_mem_cond[1];
            BR_BGTZ: br_sel = bus.ex_mem_cond[2];
            BR_BLEZ: br_sel = bus.ex_mem_cond[3];
            BR_BLTZ: br_sel = bus.ex_mem_cond[4];
            BR_BNE:  br_sel = bus.ex_mem_cond[5];
            default: br_sel = 1'b0;
        endcase
    end

    assign bus.branch_taken = !stall && bus.ex_mem_ctrl_branch && br_sel;
    assign bus.jump_taken   = !stall
                            && (bus.ex_mem_ctrl_jump || bus.ex_mem_ctrl_jump_reg);
    assign bus.stall        = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= 32'h0;
            ltype_q   <= 3'd0;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            wb_rw_q   <= 1'b0;
            wb_data_q <= 32'h0;
            wb_rd_q   <= 5'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= mis;
            unique case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_WAIT;
                    cnt_q   <= 3'(LatM1);
                    addr_q  <= bus.ex_mem_alu_out;
                    ltype_q <= bus.ex_mem_ctrl_load_type;
                    rd_q    <= bus.ex_mem_rd;
                    rw_q    <= bus.ex_mem_ctrl_reg_write;
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) state_q <= S_IDLE;
                    else cnt_q <= cnt_q - 3'd1;
                end
                default: state_q <= S_IDLE;
            endcase
            if (stall) begin
                wb_rw_q <= 1'b0;
                wb_rd_q <= 5'd0;
            end else if (done) begin
                wb_rw_q   <= rw_q;
                wb_rd_q   <= rd_q;
                wb_data_q <= ld_data;
            end else begin
                wb_rw_q   <= bus.ex_mem_ctrl_reg_write && !mis;
                wb_rd_q   <= bus.ex_mem_rd;
                wb_data_q <= is_load ? ld_data : bus.ex_mem_alu_out;
            end
        end
    end

    // Data memory survives reset; stores are a single byte-enabled write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bus.mem_wb_ctrl_reg_write = wb_rw_q;
    assign bus.mem_wb_data           = wb_data_q;
    assign bus.mem_wb_rd             = wb_rd_q;
    assign bus.addr_err              = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (ADDR_W=8, RD_LAT=2).
// Hand-computed expectations checked with immediate assertions.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.ADDR_W(8), .RD_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.ex_mem_alu_out          = 32'h0;
        bus.ex_mem_reg_b_data       = 32'h0;
        bus.ex_mem_rd               = 5'd0;
        bus.ex_mem_ctrl_reg_write   = 1'b0;
        bus.ex_mem_ctrl_mem_to_reg  = 1'b0;
        bus.ex_mem_ctrl_mem_write   = 1'b0;
        bus.ex_mem_ctrl_branch      = 1'b0;
        bus.ex_mem_ctrl_jump        = 1'b0;
        bus.ex_mem_ctrl_jump_reg    = 1'b0;
        bus.ex_mem_ctrl_load_type   = 3'd0;
        bus.ex_mem_ctrl_store_type  = 2'd0;
        bus.ex_mem_ctrl_branch_type = 3'd0;
        bus.ex_mem_cond             = 6'd0;
    endtask

    task automatic drv_st(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] t);
        clr();
        bus.ex_mem_ctrl_mem_write  = 1'b1;
        bus.ex_mem_ctrl_store_type = t;
        bus.ex_mem_alu_out         = a;
        bus.ex_mem_reg_b_data      = d;
    endtask

    task automatic drv_ld(input logic [31:0] a, input logic [2:0] t,
                          input logic [4:0] r);
        clr();
        bus.ex_mem_ctrl_mem_to_reg = 1'b1;
        bus.ex_mem_ctrl_reg_write  = 1'b1;
        bus.ex_mem_ctrl_load_type  = t;
        bus.ex_mem_alu_out         = a;
        bus.ex_mem_rd              = r;
    endtask

    // Drives a load, walks the 2-cycle stall and checks the write-back.
    task automatic load_chk(input string tag, input logic [31:0] a,
                            input logic [2:0] t, input logic [4:0] r,
                            input logic [31:0] exp);
        drv_ld(a, t, r);
        tick();
        chk({tag, "_stall1"}, bus.stall, 1);
        tick();
        chk({tag, "_stall0"}, bus.stall, 0);
        tick();
        chk({tag, "_data"}, bus.mem_wb_data, exp);
        chk({tag, "_rd"}, bus.mem_wb_rd, r);
        clr();
    endtask

    initial begin
        clr();
        #1;
        chk("rst_stall", bus.stall, 0);
        chk("rst_rw", bus.mem_wb_ctrl_reg_write, 0);
        chk("rst_data", bus.mem_wb_data, 0);
        chk("rst_rd", bus.mem_wb_rd, 0);
        chk("rst_err", bus.addr_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // SW, then LB / LBU of the top byte
        drv_st(32'h10, 32'hDEADBEEF, ST_SW);
        #1 chk("sw_nostall", bus.stall, 0);
        tick();
        chk("sw_err", bus.addr_err, 0);
        chk("sw_rw", bus.mem_wb_ctrl_reg_write, 0);
        drv_ld(32'h13, LD_LB, 5'd5);
        #1 chk("lb_comb_stall", bus.stall, 1);
        tick();
        chk("lb_bub_rw", bus.mem_wb_ctrl_reg_write, 0);
        chk("lb_bub_rd", bus.mem_wb_rd, 0);
        tick();
        chk("lb_stall_drop", bus.stall, 0);
        tick();
        chk("lb_data", bus.mem_wb_data, 32'hFFFFFFDE);
        chk("lb_rw", bus.mem_wb_ctrl_reg_write, 1);
        chk("lb_rd", bus.mem_wb_rd, 5);
        load_chk("lbu", 32'h13, LD_LBU, 5'd6, 32'h000000DE);

        // LW with bubbles; data register holds its previous value
        drv_st(32'h20, 32'h12345678, ST_SW);
        tick();
        chk("sw20_data", bus.mem_wb_data, 32'h20);
        drv_ld(32'h20, LD_LW, 5'd7);
        tick();
        chk("lw_bub1_data", bus.mem_wb_data, 32'h20);
        chk("lw_bub1_rw", bus.mem_wb_ctrl_reg_write, 0);
        chk("lw_w1_stall", bus.stall, 1);
        tick();
        chk("lw_bub2_data", bus.mem_wb_data, 32'h20);
        chk("lw_bub2_rw", bus.mem_wb_ctrl_reg_write, 0);
        tick();
        chk("lw_data", bus.mem_wb_data, 32'h12345678);
        chk("lw_rw", bus.mem_wb_ctrl_reg_write, 1);

        // Misaligned LH and SW
        drv_ld(32'h21, LD_LH, 5'd8);
        #1 chk("lh_mis_nostall", bus.stall, 0);
        tick();
        chk("lh_mis_err", bus.addr_err, 1);
        chk("lh_mis_rw", bus.mem_wb_ctrl_reg_write, 0);
        drv_st(32'h22, 32'hCAFEF00D, ST_SW);
        tick();
        chk("sw_mis_err", bus.addr_err, 1);
        clr();
        tick();
        chk("err_pulse_end", bus.addr_err, 0);
        load_chk("lw_unchanged", 32'h20, LD_LW, 5'd9, 32'h12345678);

        // Branch / jump decode with no stall
        bus.ex_mem_ctrl_branch = 1'b1;
        bus.ex_mem_ctrl_branch_type = BR_BEQ;
        bus.ex_mem_cond = 6'b111110;
        #1 chk("beq_nt", bus.branch_taken, 0);
        bus.ex_mem_cond = 6'b000001;
        #1 chk("beq_t", bus.branch_taken, 1);
        bus.ex_mem_ctrl_branch_type = 3'd6;
        bus.ex_mem_cond = 6'b111111;
        #1 chk("br_type6", bus.branch_taken, 0);
        bus.ex_mem_ctrl_branch = 1'b0;
        bus.ex_mem_ctrl_jump_reg = 1'b1;
        #1 chk("jr", bus.jump_taken, 1);
        clr();
        tick();

        // BNE arriving during a load stall
        drv_ld(32'h10, LD_LW, 5'd10);
        tick();
        clr();
        bus.ex_mem_ctrl_branch = 1'b1;
        bus.ex_mem_ctrl_branch_type = BR_BNE;
        bus.ex_mem_cond = 6'b100000;
        bus.ex_mem_ctrl_jump = 1'b1;
        #1 chk("bne_held", bus.branch_taken, 0);
        chk("j_held", bus.jump_taken, 0);
        tick();
        chk("bne_fire", bus.branch_taken, 1);
        tick();
        chk("bne_ld_data", bus.mem_wb_data, 32'hDEADBEEF);
        clr();
        #1 chk("bne_gone", bus.branch_taken, 0);

        // Wrap-around and sub-word stores
        drv_st(32'h400, 32'hA5A50001, ST_SW);
        tick();
        load_chk("wrap", 32'h0, LD_LW, 5'd11, 32'hA5A50001);
        drv_st(32'h401, 32'h00000077, ST_SB);
        tick();
        drv_st(32'h2, 32'h00008001, ST_SH);
        tick();
        load_chk("lbu1", 32'h1, LD_LBU, 5'd12, 32'h00000077);
        load_chk("lh0", 32'h0, LD_LH, 5'd13, 32'h00007701);
        load_chk("lh2", 32'h2, LD_LH, 5'd14, 32'hFFFF8001);
        load_chk("lhu2", 32'h2, LD_LHU, 5'd15, 32'h00008001);
        load_chk("lw0", 32'h0, LD_LW, 5'd16, 32'h80017701);

        // ALU pass-through
        bus.ex_mem_ctrl_reg_write = 1'b1;
        bus.ex_mem_alu_out = 32'h00000055;
        bus.ex_mem_rd = 5'd3;
        tick();
        chk("alu_data", bus.mem_wb_data, 32'h55);
        chk("alu_rd", bus.mem_wb_rd, 3);
        chk("alu_rw", bus.mem_wb_ctrl_reg_write, 1);

        // Reset in the middle of WAIT
        drv_ld(32'h10, LD_LW, 5'd17);
        tick();
        chk("pre_rst_stall", bus.stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_stall", bus.stall, 0);
        chk("mrst_data", bus.mem_wb_data, 0);
        chk("mrst_rw", bus.mem_wb_ctrl_reg_write, 0);
        chk("mrst_rd", bus.mem_wb_rd, 0);
        rst_n = 1'b1;
        load_chk("post_rst", 32'h10, LD_LW, 5'd18, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
